complex_res_accumulator: RTL and testbench

//  Result-side consumer for the complex multiplier. Acts as the slave of the
//  res_val/res_rdy handshake: accepts N_ACC signed complex products, sums real
//  and imaginary parts separately, then presents the complex sum on an
//  acc_val/acc_rdy handshake to the downstream block (complex MAC / dot product).

---
 rtl/complex_res_accumulator.sv | 110 +++++++++++
 tb/tb_complex_res_accumulator.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/complex_res_accumulator.sv
// Sums N_ACC signed complex products per group and presents the
// complex result on a valid/ready handshake toward the downstream block.
module complex_res_accumulator #(
  parameter int DATA_W = 16,
  parameter int N_ACC  = 4,
  parameter int ACC_W  = 20
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              sw_rst_i,
  input  logic              res_val_i,
  input  logic [DATA_W-1:0] res_re_i,
  input  logic [DATA_W-1:0] res_im_i,
  output logic              res_rdy_o,
  output logic              acc_val_o,
  input  logic              acc_rdy_i,
  output logic [ACC_W-1:0]  acc_re_o,
  output logic [ACC_W-1:0]  acc_im_o,
  output logic [7:0]        cnt_o
);

  typedef enum logic {
    ACCUM,
    HOLD
  } state_e;

  localparam logic [7:0] LAST = 8'(N_ACC - 1);

  state_e state_q, state_d;

  logic signed [ACC_W-1:0] acc_re_q, acc_re_d;
  logic signed [ACC_W-1:0] acc_im_q, acc_im_d;
  logic signed [ACC_W-1:0] out_re_q, out_re_d;
  logic signed [ACC_W-1:0] out_im_q, out_im_d;
  logic [7:0]              cnt_q, cnt_d;

  logic signed [ACC_W-1:0] re_ext, im_ext;
  logic signed [ACC_W-1:0] sum_re, sum_im;

  assign re_ext = ACC_W'($signed(res_re_i));
  assign im_ext = ACC_W'($signed(res_im_i));
  assign sum_re = acc_re_q + re_ext;
  assign sum_im = acc_im_q + im_ext;

  always_comb begin
    state_d  = state_q;
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    out_re_d = out_re_q;
    out_im_d = out_im_q;
    cnt_d    = cnt_q;
    if (sw_rst_i) begin
      state_d  = ACCUM;
      acc_re_d = '0;
      acc_im_d = '0;
      out_re_d = '0;
      out_im_d = '0;
      cnt_d    = '0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (res_val_i) begin
            if (cnt_q == LAST) begin
              out_re_d = sum_re;
              out_im_d = sum_im;
              acc_re_d = '0;
              acc_im_d = '0;
              cnt_d    = '0;
              state_d  = HOLD;
            end else begin
              acc_re_d = sum_re;
              acc_im_d = sum_im;
              cnt_d    = cnt_q + 8'd1;
            end
          end
        end
        HOLD: begin
          if (acc_rdy_i) state_d = ACCUM;
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= ACCUM;
      acc_re_q <= '0;
      acc_im_q <= '0;
      out_re_q <= '0;
      out_im_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
      out_re_q <= out_re_d;
      out_im_q <= out_im_d;
      cnt_q    <= cnt_d;
    end
  end

  // Handshake flags come from the state register alone
  assign res_rdy_o = (state_q == ACCUM);
  assign acc_val_o = (state_q == HOLD);
  assign acc_re_o  = out_re_q;
  assign acc_im_o  = out_im_q;
  assign cnt_o     = cnt_q;

endmodule

// File: tb/tb_complex_res_accumulator.sv
// Directed bench for complex_res_accumulator with a queue scoreboard
// of expected group sums built from a behavioural model.
module tb_complex_res_accumulator;

  localparam int DW = 16;
  localparam int AW = 20;
  localparam int NA = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          sw_rst = 1'b0;
  logic          res_val = 1'b0;
  logic [DW-1:0] res_re = '0;
  logic [DW-1:0] res_im = '0;
  logic          res_rdy;
  logic          acc_val;
  logic          acc_rdy = 1'b0;
  logic [AW-1:0] acc_re;
  logic [AW-1:0] acc_im;
  logic [7:0]    cnt;

  int checks = 0;
  int errors = 0;

  int m_re = 0;
  int m_im = 0;
  int m_cnt = 0;
  logic [2*AW-1:0] sb[$];
  logic [AW-1:0]   hold_re;

  always #5 clk = ~clk;

  complex_res_accumulator #(
    .DATA_W(DW),
    .N_ACC (NA),
    .ACC_W (AW)
  ) dut (
    .clk_i    (clk),
    .rstn_i   (rstn),
    .sw_rst_i (sw_rst),
    .res_val_i(res_val),
    .res_re_i (res_re),
    .res_im_i (res_im),
    .res_rdy_o(res_rdy),
    .acc_val_o(acc_val),
    .acc_rdy_i(acc_rdy),
    .acc_re_o (acc_re),
    .acc_im_o (acc_im),
    .cnt_o    (cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input int re, input int im);
    logic [AW-1:0] er, ei;
    bit done = 0;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      res_val = 1'b1;
      res_re  = DW'(re);
      res_im  = DW'(im);
      if (res_rdy) done = 1;
      @(posedge clk);
      #1 res_val = 1'b0;
    end
    if (!done) chk("put_timeout", 64'(res_rdy), 64'd1);
    else begin
      m_re += re;
      m_im += im;
      m_cnt++;
      if (m_cnt == NA) begin
        er = AW'(m_re);
        ei = AW'(m_im);
        sb.push_back({er, ei});
        m_re = 0;
        m_im = 0;
        m_cnt = 0;
      end
    end
  endtask

  task automatic get(input string tag);
    logic [2*AW-1:0] e;
    bit seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (acc_val) seen = 1;
    end
    if (!seen) chk({tag, "_timeout"}, 64'(acc_val), 64'd1);
    else if (sb.size() == 0) chk({tag, "_sb_empty"}, 64'd0, 64'd1);
    else begin
      e = sb.pop_front();
      chk({tag, "_re"}, 64'(acc_re), 64'(e[2*AW-1:AW]));
      chk({tag, "_im"}, 64'(acc_im), 64'(e[AW-1:0]));
      acc_rdy = 1'b1;
      @(posedge clk);
      #1 acc_rdy = 1'b0;
      @(negedge clk);
      chk({tag, "_val_drop"}, 64'(acc_val), 64'd0);
      chk({tag, "_rdy_back"}, 64'(res_rdy), 64'd1);
      chk({tag, "_retain"}, 64'(acc_re), 64'(e[2*AW-1:AW]));
    end
  endtask

  initial begin
    #3;
    chk("rst_rdy", 64'(res_rdy), 64'd1);
    chk("rst_val", 64'(acc_val), 64'd0);
    chk("rst_cnt", 64'(cnt), 64'd0);
    chk("rst_re", 64'(acc_re), 64'd0);
    chk("rst_im", 64'(acc_im), 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    // T1 back-to-back, one-cycle latency
    for (int i = 0; i < 4; i++) put(2, 16);
    @(negedge clk);
    chk("t1_lat", 64'(acc_val), 64'd1);
    chk("t1_rdy_low", 64'(res_rdy), 64'd0);
    get("t1");

    // T2 sign extension
    put(-100, 0);
    put(50, -7);
    put(-1, -1);
    put(0, 8);
    chk("t2_const", 64'(sb[0][2*AW-1:AW]), 64'h0FFFCD);
    get("t2");

    // T3 downstream stall with upstream offering
    for (int i = 0; i < 4; i++) put(5, -3);
    @(negedge clk);
    res_val = 1'b1;
    res_re  = 16'd7;
    res_im  = 16'd7;
    hold_re = acc_re;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_val", 64'(acc_val), 64'd1);
      chk("t3_rdy", 64'(res_rdy), 64'd0);
      chk("t3_cnt", 64'(cnt), 64'd0);
      chk("t3_stable", 64'(acc_re), 64'(hold_re));
    end
    res_val = 1'b0;
    get("t3");
    put(7, 7);
    for (int i = 0; i < 3; i++) put(1, 2);
    get("t3b");

    // T4 gaps in res_val
    for (int i = 0; i < 4; i++) begin
      repeat (2) begin
        @(negedge clk);
        chk("t4_cnt", 64'(cnt), 64'(i));
      end
      put(2, 16);
    end
    get("t4");

    // T5 soft reset mid-group wins over a valid product
    put(3, 3);
    put(3, 3);
    @(negedge clk);
    chk("t5_cnt_pre", 64'(cnt), 64'd2);
    sw_rst  = 1'b1;
    res_val = 1'b1;
    res_re  = 16'd9;
    res_im  = 16'd9;
    @(posedge clk);
    #1;
    sw_rst  = 1'b0;
    res_val = 1'b0;
    m_re = 0;
    m_im = 0;
    m_cnt = 0;
    @(negedge clk);
    chk("t5_cnt", 64'(cnt), 64'd0);
    chk("t5_out", 64'(acc_re), 64'd0);
    chk("t5_rdy", 64'(res_rdy), 64'd1);
    for (int i = 0; i < 4; i++) put(1, 1);
    get("t5");

    // T6 async reset while holding
    for (int i = 0; i < 4; i++) put(10, 20);
    @(negedge clk);
    chk("t6_val_pre", 64'(acc_val), 64'd1);
    #2 rstn = 1'b0;
    #1;
    chk("t6_val", 64'(acc_val), 64'd0);
    chk("t6_cnt", 64'(cnt), 64'd0);
    chk("t6_re", 64'(acc_re), 64'd0);
    chk("t6_im", 64'(acc_im), 64'd0);
    if (sb.size() > 0) void'(sb.pop_front());
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("t6_rdy", 64'(res_rdy), 64'd1);
    for (int i = 0; i < 4; i++) put(-1, 1);
    get("t6b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
